egg_timer_ctrl: RTL and testbench
=================================

// Module: egg_timer_ctrl
// PURPOSE
//  Countdown controller for the egg timer. Consumes 1-clk tick pulses from clock_divider
//  and sequences that divider via div_reset. Holds the user-set MM:SS time as BCD digits,
//  then runs, pauses and clears it and raises the alarm when the count reaches 00:00.
//  Sits between the debounced button pulses and the 7-seg display driver.
// PARAMETERS
//  TICKS_PER_SEC  10  tick pulses per second of countdown (divider rate); >=2
//  ALARM_SECS     5   seconds alarm stays asserted before auto-return to IDLE; >=1
//  SUB_W          4   width of sub-second tick counter; 2**SUB_W >= TICKS_PER_SEC
// PORTS
//  clk         in   1   system clock; all logic on posedge clk
//  reset       in   1   synchronous, active-high reset
//  tick        in   1   1-clk pulse from clock_divider
//  start_stop  in   1   1-clk button pulse: start / pause / resume / alarm ack
//  clear       in   1   1-clk button pulse: abort, zero the time
//  inc_min     in   1   1-clk pulse: minutes +1 (setting only)
//  inc_sec     in   1   1-clk pulse: seconds +1 (setting only)
//  div_reset   out  1   hold clock_divider in reset (realigns the first second)
//  min_tens    out  4   BCD 0-9
//  min_ones    out  4   BCD 0-9
//  sec_tens    out  4   BCD 0-5
//  sec_ones    out  4   BCD 0-9
//  running     out  1   1 while in RUN
//  alarm       out  1   1 while in ALARM
// BEHAVIOUR
//  - All outputs registered. On reset: state IDLE, all digits 0, sub_cnt 0, alarm_cnt 0,
//    running 0, alarm 0, div_reset 1.
//  - States IDLE, RUN, PAUSE, ALARM. div_reset=1 in IDLE/PAUSE, 0 in RUN/ALARM.
//    running=(RUN), alarm=(ALARM). Each asserts the cycle after the state is entered.
//  - Input priority per cycle: clear > start_stop > inc_* > tick.
//  - clear (any state): next IDLE, digits 0, sub_cnt 0, alarm_cnt 0.
//  - start_stop: IDLE & time!=00:00 -> RUN (sub_cnt 0). IDLE & 00:00 -> ignored.
//    RUN -> PAUSE (sub_cnt kept). PAUSE -> RUN. ALARM -> IDLE (digits stay 00:00).
//  - inc_sec (IDLE/PAUSE): seconds +1 in BCD; 59 wraps to 00, no carry into minutes.
//    inc_min (IDLE/PAUSE): minutes +1 in BCD; 99 wraps to 00.
//    Both in one cycle: both applied. Ignored in RUN/ALARM.
//  - tick in RUN: if sub_cnt==TICKS_PER_SEC-1 then sub_cnt<=0 and decrement time by 1 s,
//    else sub_cnt+1. tick in IDLE/PAUSE: ignored.
//  - BCD decrement: sec_ones 0->9 borrows; sec_tens 0->5 borrows; min_ones 0->9 borrows.
//    Decrement never applied at 00:00.
//  - Expiry: the decrement that yields 00:00 also moves to ALARM in the same cycle;
//    alarm_cnt cleared.
//  - ALARM: alarm_cnt+1 per tick. At ALARM_SECS*TICKS_PER_SEC-1 plus a tick -> IDLE,
//    alarm 0 next cycle.
//  - tick coincident with start_stop/clear: tick dropped (no decrement, no sub_cnt change).
//  - reset mid-RUN/ALARM: immediate return to reset values on that edge.
// TESTING (TICKS_PER_SEC=2, ALARM_SECS=2 in bench)
//  1 reset; check digits 0000, div_reset=1, running=0, alarm=0; start_stop at 00:00
//    -> state stays IDLE.
//  2 inc_sec x61 -> 00:01; inc_min x100 -> 00:01 (minute wrap); inc_min+inc_sec
//    same cycle -> 01:02.
//  3 set 01:00, start_stop -> running=1, div_reset=0; 2 ticks -> 00:59; 118 more ticks
//    -> 00:00 and alarm=1 next cycle.
//  4 RUN 00:10, 1 tick (sub_cnt=1), start_stop -> PAUSE; 3 ticks -> no change;
//    start_stop, 1 tick -> 00:09.
//  5 ALARM: 4 ticks -> alarm=0, IDLE. Repeat, start_stop at alarm -> IDLE immediately.
//  6 tick+start_stop same cycle in RUN -> PAUSE, time unchanged; clear mid-RUN at 05:30
//    -> 00:00 IDLE; reset mid-RUN -> reset values.

Source files
------------

// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown controller.
// Holds an MM:SS time as four BCD digits, lets the user set it while idle or
// paused, counts it down on divider ticks while running, and raises the alarm
// for a fixed number of seconds once the count reaches 00:00.
//
// Handshake note: every control input is a single-cycle pulse and there is no
// backpressure. A pulse is consumed on the clock edge where it is high. When
// several pulses arrive together, the lower-priority ones are dropped, in this
// order: clear > start_stop > inc_min/inc_sec > tick.
module egg_timer_ctrl #(
  parameter int TICKS_PER_SEC = 10,
  parameter int ALARM_SECS    = 5,
  parameter int SUB_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic       div_reset,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state_dbg
);

  localparam int ALARM_LIM = ALARM_SECS * TICKS_PER_SEC;
  localparam int ALARM_W   = (ALARM_LIM > 2) ? $clog2(ALARM_LIM) : 1;

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_LIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [15:0]        time_q, time_nx;
  logic [SUB_W-1:0]   sub_cnt, sub_nx;
  logic [ALARM_W-1:0] alarm_cnt, alarm_nx;

  logic [15:0] time_inc;
  logic [15:0] time_dec;
  logic        time_zero;
  logic        dec_zero;

  // BCD arithmetic on the held time: increments for setting, one-second decrement
  always_comb begin
    time_inc = time_q;
    if (inc_sec) begin
      if (time_q[3:0] == 4'd9) begin
        time_inc[3:0] = 4'd0;
        time_inc[7:4] = (time_q[7:4] == 4'd5) ? 4'd0 : time_q[7:4] + 4'd1;
      end else begin
        time_inc[3:0] = time_q[3:0] + 4'd1;
      end
    end
    if (inc_min) begin
      if (time_q[11:8] == 4'd9) begin
        time_inc[11:8]  = 4'd0;
        time_inc[15:12] = (time_q[15:12] == 4'd9) ? 4'd0 : time_q[15:12] + 4'd1;
      end else begin
        time_inc[11:8] = time_q[11:8] + 4'd1;
      end
    end

    // Borrow chain; only used when the time is non-zero, so min_tens never underflows
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else begin
      time_dec[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        time_dec[7:4] = time_q[7:4] - 4'd1;
      end else begin
        time_dec[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          time_dec[11:8] = time_q[11:8] - 4'd1;
        end else begin
          time_dec[11:8]  = 4'd9;
          time_dec[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end

    time_zero = (time_q == 16'h0000);
    dec_zero  = (time_dec == 16'h0000);
  end

  // Next-state decision, applying input priority clear > start_stop > inc > tick
  always_comb begin
    state_nx = state;
    time_nx  = time_q;
    sub_nx   = sub_cnt;
    alarm_nx = alarm_cnt;

    if (clear) begin
      state_nx = IDLE;
      time_nx  = 16'h0000;
      sub_nx   = '0;
      alarm_nx = '0;
    end else if (start_stop) begin
      case (state)
        IDLE: begin
          if (!time_zero) begin
            state_nx = RUN;
            sub_nx   = '0;
          end
        end
        RUN:   state_nx = PAUSE;
        PAUSE: state_nx = RUN;
        ALARM: begin
          state_nx = IDLE;
          alarm_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end else if ((inc_min || inc_sec) && (state == IDLE || state == PAUSE)) begin
      time_nx = time_inc;
    end else if (tick) begin
      if (state == RUN) begin
        if (sub_cnt == SUB_LAST) begin
          sub_nx = '0;
          if (!time_zero) begin
            time_nx = time_dec;
            if (dec_zero) begin
              state_nx = ALARM;
              alarm_nx = '0;
            end
          end
        end else begin
          sub_nx = sub_cnt + 1'b1;
        end
      end else if (state == ALARM) begin
        if (alarm_cnt == ALARM_LAST) begin
          state_nx = IDLE;
          alarm_nx = '0;
        end else begin
          alarm_nx = alarm_cnt + 1'b1;
        end
      end
    end
  end

  // State, counters and registered outputs, all updated together
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      time_q    <= 16'h0000;
      sub_cnt   <= '0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      div_reset <= 1'b1;
    end else begin
      state     <= state_nx;
      time_q    <= time_nx;
      sub_cnt   <= sub_nx;
      alarm_cnt <= alarm_nx;
      running   <= (state_nx == RUN);
      alarm     <= (state_nx == ALARM);
      div_reset <= (state_nx == IDLE) || (state_nx == PAUSE);
    end
  end

  assign min_tens  = time_q[15:12];
  assign min_ones  = time_q[11:8];
  assign sec_tens  = time_q[7:4];
  assign sec_ones  = time_q[3:0];
  assign state_dbg = state;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl with TICKS_PER_SEC=2, ALARM_SECS=2.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_egg_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic       inc_min;
  logic       inc_sec;
  logic       div_reset;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       alarm;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  typedef struct {
    logic        ss;
    logic        clr;
    logic        im;
    logic        is;
    logic        tk;
    logic [15:0] dig;
    logic        run;
    logic        al;
    logic        dr;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[18];

  egg_timer_ctrl #(
    .TICKS_PER_SEC(2),
    .ALARM_SECS   (2),
    .SUB_W        (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start_stop(start_stop),
    .clear     (clear),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .div_reset (div_reset),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .alarm     (alarm),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given pulses, then return all pulses low
  task automatic drive(input logic ss, input logic clr, input logic im,
                       input logic is, input logic tk);
    start_stop = ss;
    clear      = clr;
    inc_min    = im;
    inc_sec    = is;
    tick       = tk;
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    inc_min    = 1'b0;
    inc_sec    = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [15:0] dig, input logic run,
                       input logic al, input logic dr, input logic [1:0] st);
    logic [20:0] got;
    logic [20:0] exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, running, alarm, div_reset, state_dbg};
    exp = {dig, run, al, dr, st};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got time=%h run=%b alarm=%b div_reset=%b state=%0d, expected time=%h run=%b alarm=%b div_reset=%b state=%0d",
               name, got[20:5], got[4], got[3], got[2], got[1:0], dig, run, al, dr, st);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    tick       = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    inc_min    = 1'b0;
    inc_sec    = 1'b0;

    //             ss    clr   im    is    tk    time      run   al    dr    state
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, S_IDLE};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0102, 1'b0, 1'b0, 1'b1, S_IDLE};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, S_IDLE};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0102, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0102, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, S_PAUSE};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0201, 1'b0, 1'b0, 1'b1, S_PAUSE};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 1'b1, S_PAUSE};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0201, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0201, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0159, 1'b1, 1'b0, 1'b0, S_RUN};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE};

    @(negedge clk);
    do_reset();
    check("reset_values", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ss, tbl[i].clr, tbl[i].im, tbl[i].is, tbl[i].tk);
      check($sformatf("vec%0d", i), tbl[i].dig, tbl[i].run, tbl[i].al, tbl[i].dr, tbl[i].st);
    end

    // Setting wraps: 61 second increments, 100 minute increments
    do_reset();
    for (int i = 0; i < 59; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sec_59", 16'h0059, 1'b0, 1'b0, 1'b1, S_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sec_wrap_no_carry", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("inc_sec_x61", 16'h0001, 1'b0, 1'b0, 1'b1, S_IDLE);
    for (int i = 0; i < 99; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("min_99", 16'h9901, 1'b0, 1'b0, 1'b1, S_IDLE);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("inc_min_x100", 16'h0001, 1'b0, 1'b0, 1'b1, S_IDLE);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("inc_both", 16'h0102, 1'b0, 1'b0, 1'b1, S_IDLE);

    // Full countdown from 01:00 into ALARM
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_0100", 16'h0100, 1'b1, 1'b0, 1'b0, S_RUN);
    ticks(2);
    check("first_sec_0059", 16'h0059, 1'b1, 1'b0, 1'b0, S_RUN);
    ticks(116);
    check("near_end_0001", 16'h0001, 1'b1, 1'b0, 1'b0, S_RUN);
    ticks(2);
    check("expire_alarm", 16'h0000, 1'b0, 1'b1, 1'b0, S_ALARM);

    // Alarm auto-return after ALARM_SECS*TICKS_PER_SEC ticks
    ticks(3);
    check("alarm_held", 16'h0000, 1'b0, 1'b1, 1'b0, S_ALARM);
    ticks(1);
    check("alarm_timeout", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);

    // Alarm acknowledged by start_stop
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    check("alarm_again", 16'h0000, 1'b0, 1'b1, 1'b0, S_ALARM);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("alarm_ack", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);

    // Pause keeps the sub-second count
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check("paused_0010", 16'h0010, 1'b0, 1'b0, 1'b1, S_PAUSE);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check("resume_0009", 16'h0009, 1'b1, 1'b0, 1'b0, S_RUN);

    // Borrow through minutes tens: 10:00 -> 09:59
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    check("borrow_0959", 16'h0959, 1'b1, 1'b0, 1'b0, S_RUN);

    // Clear mid-RUN at 05:30
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check("run_0530", 16'h0530, 1'b1, 1'b0, 1'b0, S_RUN);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clear_mid_run", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);

    // Reset mid-RUN, then mid-ALARM
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_mid_run", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check("alarm_before_reset", 16'h0000, 1'b0, 1'b1, 1'b0, S_ALARM);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_mid_alarm", 16'h0000, 1'b0, 1'b0, 1'b1, S_IDLE);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
